meteor_game_ctrl: RTL and testbench

Game-state controller that sits directly upstream of the meteor mover/renderer. It produces the per-meteor alive flags, the horizontal speed and the 4-bit score that the renderer consumes. It consumes pixel-level collision pulses from the collision detector and the player start button. It owns per-meteor destroy/respawn sequencing, scoring, lives and the IDLE/PLAY/GAME_OVER state machine.

---
 rtl/game_pkg.sv | 39 +++
 rtl/meteor_game_ctrl_if.sv | 33 +++
 rtl/meteor_slot.sv | 63 ++++++
 rtl/meteor_game_ctrl.sv | 150 +++++++++++++++
 tb/tb_meteor_game_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types, widths and defaults for the meteor game controller.
// Holds the top FSM and meteor slot encodings plus the saturating score add.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } game_state_e;

    typedef enum logic {
        DEAD  = 1'b0,
        ALIVE = 1'b1
    } slot_state_e;

    localparam int SCORE_W = 4;
    localparam int SPEED_W = 5;
    localparam int LIVES_W = 2;
    localparam int CNT_W   = 6;

    localparam int DEF_RESPAWN_FRAMES = 45;
    localparam int DEF_INVULN_FRAMES  = 60;
    localparam int DEF_BASE_SPEED     = 2;
    localparam int DEF_START_LIVES    = 3;
    localparam int DEF_M3_SCORE       = 7;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Add this cycle's kill count to the score, clamping at the top.
    function automatic logic [SCORE_W-1:0] score_add(
        input logic [SCORE_W-1:0] s,
        input logic [1:0]         n
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(n);
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/meteor_game_ctrl_if.sv
// Game I/O bundle between the controller and its neighbours.
// master is the controller side; slave is the renderer/detector side.
interface meteor_game_ctrl_if;
    import game_pkg::*;

    logic               v_sync;
    logic               start;
    logic               hit_m1;
    logic               hit_m2;
    logic               hit_m3;
    logic               ship_hit;
    logic               m1_alive;
    logic               m2_alive;
    logic               m3_alive;
    logic [SPEED_W-1:0] speed_out;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic               game_over;
    logic               playing;

    modport master (
        input  v_sync, start, hit_m1, hit_m2, hit_m3, ship_hit,
        output m1_alive, m2_alive, m3_alive,
        output speed_out, score, lives, game_over, playing
    );

    modport slave (
        output v_sync, start, hit_m1, hit_m2, hit_m3, ship_hit,
        input  m1_alive, m2_alive, m3_alive,
        input  speed_out, score, lives, game_over, playing
    );

endinterface

// File: rtl/meteor_slot.sv
// One meteor's destroy/respawn sequencer.
// arm forces ALIVE; enable low holds the slot DEAD with an empty counter.
module meteor_slot
    import game_pkg::*;
#(
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic enable,
    input  logic hit,
    input  logic arm,
    output logic alive,
    output logic kill
);

    slot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A hit only scores against a live meteor; dead hits are ignored.
    assign kill  = (state_q == ALIVE) && hit;
    assign alive = (state_q == ALIVE);

    // Slot state and respawn counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: kill loads the respawn count, last frame tick re-arms.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (arm) begin
            state_d = ALIVE;
            cnt_d   = '0;
        end else if (!enable) begin
            state_d = DEAD;
            cnt_d   = '0;
        end else if (state_q == ALIVE) begin
            if (hit) begin
                state_d = DEAD;
                cnt_d   = CNT_W'(RESPAWN_FRAMES);
            end
        end else if (cnt_q == '0) begin
            state_d = ALIVE;
        end else if (frame_tick) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = ALIVE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/meteor_game_ctrl.sv
// Game-state controller: top FSM, scoring, lives and invulnerability.
// Drives meteor alive flags, speed and score to the renderer.
module meteor_game_ctrl
    import game_pkg::*;
#(
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES,
    parameter int BASE_SPEED     = DEF_BASE_SPEED,
    parameter int START_LIVES    = DEF_START_LIVES,
    parameter int M3_SCORE       = DEF_M3_SCORE
) (
    input logic                clk,
    input logic                rst_n,
    meteor_game_ctrl_if.master bus
);

    logic [2:0]         vs_q;
    logic               frame_tick;
    game_state_e        state_q, state_d;
    logic               seen_low_q, seen_low_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   inv_q, inv_d;
    logic [SPEED_W-1:0] speed_q;
    logic               playing_q, over_q;
    logic               in_play, go, m3_on;
    logic               ship_ok, fatal, next_play;
    logic               k1, k2, k3;
    logic               a1, a2, a3;
    logic [1:0]         n_kill;

    // v_sync is asynchronous: two-flop sync plus edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= '0;
        end else begin
            vs_q <= {vs_q[1:0], bus.v_sync};
        end
    end

    assign frame_tick = vs_q[1] & ~vs_q[2];

    assign in_play = (state_q == PLAY);
    assign go      = bus.start &&
                     ((state_q == IDLE) ||
                      (state_q == GAME_OVER && seen_low_q));
    assign m3_on   = in_play && (score_q >= SCORE_W'(M3_SCORE));
    assign ship_ok = in_play && bus.ship_hit && (inv_q == '0);
    assign fatal   = ship_ok && (lives_q == LIVES_W'(1));
    assign n_kill  = {1'b0, k1} + {1'b0, k2} + {1'b0, k3};

    // Top FSM and per-game counters, next-state side.
    always_comb begin
        state_d    = state_q;
        seen_low_d = seen_low_q;
        score_d    = score_q;
        lives_d    = lives_q;
        inv_d      = inv_q;
        unique case (state_q)
            IDLE:      if (go) state_d = PLAY;
            PLAY:      if (fatal) state_d = GAME_OVER;
            GAME_OVER: if (go) state_d = PLAY;
            default:   state_d = IDLE;
        endcase
        seen_low_d = (state_q == GAME_OVER) &&
                     (seen_low_q || !bus.start);
        if (go) begin
            score_d = '0;
            lives_d = LIVES_W'(START_LIVES);
            inv_d   = '0;
        end else if (in_play) begin
            score_d = score_add(score_q, n_kill);
            if (ship_ok) begin
                lives_d = lives_q - 1'b1;
                inv_d   = CNT_W'(INVULN_FRAMES);
            end else if (frame_tick && inv_q != '0) begin
                inv_d = inv_q - 1'b1;
            end
        end
    end

    assign next_play = (state_d == PLAY);

    // Registered game state and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seen_low_q <= 1'b0;
            score_q    <= '0;
            lives_q    <= LIVES_W'(START_LIVES);
            inv_q      <= '0;
            speed_q    <= SPEED_W'(BASE_SPEED);
            playing_q  <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seen_low_q <= seen_low_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            inv_q      <= inv_d;
            speed_q    <= SPEED_W'(BASE_SPEED) +
                          SPEED_W'(score_q[SCORE_W-1:1]);
            playing_q  <= (state_d == PLAY);
            over_q     <= (state_d == GAME_OVER);
        end
    end

    meteor_slot #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .enable     (next_play),
        .hit        (in_play & bus.hit_m1),
        .arm        (go),
        .alive      (a1),
        .kill       (k1)
    );

    meteor_slot #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_slot2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .enable     (next_play),
        .hit        (in_play & bus.hit_m2),
        .arm        (go),
        .alive      (a2),
        .kill       (k2)
    );

    meteor_slot #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_slot3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .enable     (next_play & m3_on),
        .hit        (m3_on & bus.hit_m3),
        .arm        (1'b0),
        .alive      (a3),
        .kill       (k3)
    );

    assign bus.m1_alive  = a1;
    assign bus.m2_alive  = a2;
    assign bus.m3_alive  = a3;
    assign bus.speed_out = speed_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = over_q;
    assign bus.playing   = playing_q;

endmodule

// File: tb/tb_meteor_game_ctrl.sv
// Directed bench for meteor_game_ctrl.
// Each task drives one scenario and checks hand-computed values.
module tb_meteor_game_ctrl;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    meteor_game_ctrl_if bus();

    meteor_game_ctrl #(
        .RESPAWN_FRAMES (45),
        .INVULN_FRAMES  (60),
        .BASE_SPEED     (2),
        .START_LIVES    (3),
        .M3_SCORE       (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One video frame: one v_sync rising edge, 8 clocks long.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.v_sync = 1'b1;
            step(4);
            bus.v_sync = 1'b0;
            step(4);
        end
    endtask

    task automatic hits(input logic h1, input logic h2, input logic h3);
        bus.hit_m1 = h1;
        bus.hit_m2 = h2;
        bus.hit_m3 = h3;
        step(1);
        bus.hit_m1 = 1'b0;
        bus.hit_m2 = 1'b0;
        bus.hit_m3 = 1'b0;
    endtask

    task automatic test_reset;
        logic [4:0] flags;
        rst_n = 1'b0;
        bus.v_sync = 1'b0;
        bus.start = 1'b0;
        bus.hit_m1 = 1'b0;
        bus.hit_m2 = 1'b0;
        bus.hit_m3 = 1'b0;
        bus.ship_hit = 1'b0;
        step(2);
        flags = {bus.m1_alive, bus.m2_alive, bus.m3_alive,
                 bus.game_over, bus.playing};
        checks++;
        if (flags !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", flags);
        end
        checks++;
        if (bus.score !== 4'd0 || bus.lives !== 2'd3 ||
            bus.speed_out !== 5'd2) begin
            errors++;
            $display("FAIL reset_vals got s=%0d l=%0d v=%0d want 0 3 2",
                     bus.score, bus.lives, bus.speed_out);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_start;
        logic [2:0] al;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        al = {bus.m1_alive, bus.m2_alive, bus.m3_alive};
        checks++;
        if (bus.playing !== 1'b1 || al !== 3'b110) begin
            errors++;
            $display("FAIL start got play=%b alive=%b want 1 110",
                     bus.playing, al);
        end
        checks++;
        if (bus.score !== 4'd0 || bus.lives !== 2'd3 ||
            bus.speed_out !== 5'd2) begin
            errors++;
            $display("FAIL start_vals got s=%0d l=%0d v=%0d want 0 3 2",
                     bus.score, bus.lives, bus.speed_out);
        end
    endtask

    task automatic test_kill_hold;
        bus.hit_m1 = 1'b1;
        step(1);
        checks++;
        if (bus.m1_alive !== 1'b0 || bus.score !== 4'd1) begin
            errors++;
            $display("FAIL kill_first got a=%b s=%0d want 0 1",
                     bus.m1_alive, bus.score);
        end
        step(199);
        bus.hit_m1 = 1'b0;
        checks++;
        if (bus.score !== 4'd1) begin
            errors++;
            $display("FAIL kill_held got s=%0d want 1", bus.score);
        end
        frames(44);
        checks++;
        if (bus.m1_alive !== 1'b0) begin
            errors++;
            $display("FAIL respawn_early got a=%b want 0", bus.m1_alive);
        end
        bus.v_sync = 1'b1;
        step(2);
        checks++;
        if (bus.m1_alive !== 1'b0) begin
            errors++;
            $display("FAIL respawn_tick got a=%b want 0", bus.m1_alive);
        end
        step(1);
        checks++;
        if (bus.m1_alive !== 1'b1) begin
            errors++;
            $display("FAIL respawn got a=%b want 1", bus.m1_alive);
        end
        step(1);
        bus.v_sync = 1'b0;
        step(4);
    endtask

    task automatic test_m3_unlock;
        hits(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.score !== 4'd3) begin
            errors++;
            $display("FAIL pair_kill got s=%0d want 3", bus.score);
        end
        frames(45);
        hits(1'b1, 1'b1, 1'b0);
        frames(45);
        checks++;
        if (bus.score !== 4'd5 || bus.m1_alive !== 1'b1 ||
            bus.m2_alive !== 1'b1) begin
            errors++;
            $display("FAIL score5 got s=%0d a1=%b a2=%b want 5 1 1",
                     bus.score, bus.m1_alive, bus.m2_alive);
        end
        hits(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.score !== 4'd6 || bus.speed_out !== 5'd4) begin
            errors++;
            $display("FAIL speed_lag got s=%0d v=%0d want 6 4",
                     bus.score, bus.speed_out);
        end
        step(1);
        checks++;
        if (bus.speed_out !== 5'd5) begin
            errors++;
            $display("FAIL speed6 got v=%0d want 5", bus.speed_out);
        end
        hits(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.score !== 4'd6 || bus.m3_alive !== 1'b0) begin
            errors++;
            $display("FAIL m3_locked got s=%0d a3=%b want 6 0",
                     bus.score, bus.m3_alive);
        end
        hits(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.score !== 4'd7 || bus.m3_alive !== 1'b0) begin
            errors++;
            $display("FAIL m3_edge got s=%0d a3=%b want 7 0",
                     bus.score, bus.m3_alive);
        end
        step(1);
        checks++;
        if (bus.m3_alive !== 1'b1) begin
            errors++;
            $display("FAIL m3_unlock got a3=%b want 1", bus.m3_alive);
        end
    endtask

    task automatic test_saturate;
        logic [2:0] al;
        frames(45);
        hits(1'b1, 1'b1, 1'b1);
        al = {bus.m1_alive, bus.m2_alive, bus.m3_alive};
        checks++;
        if (bus.score !== 4'd10 || al !== 3'b000) begin
            errors++;
            $display("FAIL triple got s=%0d alive=%b want 10 000",
                     bus.score, al);
        end
        frames(45);
        hits(1'b1, 1'b0, 1'b1);
        frames(45);
        hits(1'b1, 1'b0, 1'b1);
        frames(45);
        al = {bus.m1_alive, bus.m2_alive, bus.m3_alive};
        checks++;
        if (bus.score !== 4'd14 || al !== 3'b111) begin
            errors++;
            $display("FAIL score14 got s=%0d alive=%b want 14 111",
                     bus.score, al);
        end
        hits(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.score !== 4'd15) begin
            errors++;
            $display("FAIL saturate got s=%0d want 15", bus.score);
        end
        step(1);
        checks++;
        if (bus.speed_out !== 5'd9) begin
            errors++;
            $display("FAIL speed_max got v=%0d want 9", bus.speed_out);
        end
    endtask

    task automatic test_ship;
        bus.ship_hit = 1'b1;
        frames(3);
        checks++;
        if (bus.lives !== 2'd2) begin
            errors++;
            $display("FAIL ship_once got l=%0d want 2", bus.lives);
        end
        frames(56);
        checks++;
        if (bus.lives !== 2'd2) begin
            errors++;
            $display("FAIL invuln got l=%0d want 2", bus.lives);
        end
        frames(1);
        bus.ship_hit = 1'b0;
        checks++;
        if (bus.lives !== 2'd1 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL ship_again got l=%0d go=%b want 1 0",
                     bus.lives, bus.game_over);
        end
    endtask

    task automatic test_game_over;
        logic [2:0] al;
        frames(60);
        bus.start = 1'b1;
        bus.ship_hit = 1'b1;
        step(1);
        bus.ship_hit = 1'b0;
        al = {bus.m1_alive, bus.m2_alive, bus.m3_alive};
        checks++;
        if (bus.game_over !== 1'b1 || bus.playing !== 1'b0 ||
            bus.lives !== 2'd0 || al !== 3'b000) begin
            errors++;
            $display("FAIL fatal got go=%b p=%b l=%0d alive=%b want 1 0 0 000",
                     bus.game_over, bus.playing, bus.lives, al);
        end
        step(5);
        checks++;
        if (bus.game_over !== 1'b1 || bus.score !== 4'd15) begin
            errors++;
            $display("FAIL held_start got go=%b s=%0d want 1 15",
                     bus.game_over, bus.score);
        end
        bus.start = 1'b0;
        step(1);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        al = {bus.m1_alive, bus.m2_alive, bus.m3_alive};
        checks++;
        if (bus.playing !== 1'b1 || bus.game_over !== 1'b0 ||
            bus.score !== 4'd0 || bus.lives !== 2'd3 ||
            al !== 3'b110) begin
            errors++;
            $display("FAIL restart got p=%b go=%b s=%0d l=%0d alive=%b",
                     bus.playing, bus.game_over, bus.score, bus.lives, al);
        end
        step(1);
        checks++;
        if (bus.speed_out !== 5'd2) begin
            errors++;
            $display("FAIL restart_speed got v=%0d want 2", bus.speed_out);
        end
    endtask

    task automatic test_reset_mid;
        logic [4:0] flags;
        hits(1'b1, 1'b1, 1'b0);
        frames(45);
        hits(1'b1, 1'b1, 1'b0);
        frames(45);
        hits(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.score !== 4'd5 || bus.m3_alive !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset got s=%0d a3=%b want 5 0",
                     bus.score, bus.m3_alive);
        end
        step(1);
        bus.v_sync = 1'b1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        flags = {bus.m1_alive, bus.m2_alive, bus.m3_alive,
                 bus.game_over, bus.playing};
        checks++;
        if (flags !== 5'b0 || bus.score !== 4'd0 ||
            bus.lives !== 2'd3 || bus.speed_out !== 5'd2) begin
            errors++;
            $display("FAIL async_rst got f=%b s=%0d l=%0d v=%0d",
                     flags, bus.score, bus.lives, bus.speed_out);
        end
        step(2);
        rst_n = 1'b1;
        bus.v_sync = 1'b0;
        step(3);
        flags = {bus.m1_alive, bus.m2_alive, bus.m3_alive,
                 bus.game_over, bus.playing};
        checks++;
        if (flags !== 5'b0) begin
            errors++;
            $display("FAIL post_rst got f=%b want 00000", flags);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_kill_hold();
        test_m3_unlock();
        test_saturate();
        test_ship();
        test_game_over();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
